// File: rtl/wave_engine.sv
// wave_engine: owns the three falling walls of the dodge game.
// It tracks each wall's row and its occupancy bitfield with a random gap,
// detects player/wall collisions, and keeps the current and best score.
module wave_engine #(
    parameter int BOARD_HEIGHT = 20,
    parameter int BOARD_WIDTH  = 40,
    parameter int WAVE_SPACING = 6,
    parameter int GAP_WIDTH    = 4,
    parameter int TICK_DIV     = 50000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             player_x,
    input  logic [7:0]             player_y,
    output logic [7:0]             wave1_y,
    output logic [7:0]             wave2_y,
    output logic [7:0]             wave3_y,
    output logic [BOARD_WIDTH-1:0] wave1_bitfield,
    output logic [BOARD_WIDTH-1:0] wave2_bitfield,
    output logic [BOARD_WIDTH-1:0] wave3_bitfield,
    output logic [15:0]            score,
    output logic [15:0]            high_score,
    output logic                   game_over
);

    localparam int              CNT_W   = $clog2(TICK_DIV);
    localparam int              MAX_POS = BOARD_WIDTH - GAP_WIDTH;
    localparam logic [7:0]      Y1_INIT = 8'(BOARD_HEIGHT - 2);
    localparam logic [7:0]      Y2_INIT = 8'(BOARD_HEIGHT - 2 - WAVE_SPACING);
    localparam logic [7:0]      Y3_INIT = 8'(BOARD_HEIGHT - 2 - 2 * WAVE_SPACING);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       tick_cnt;
    logic [15:0]            lfsr;

    logic                   lfsr_fb;
    logic                   tick;
    logic                   collide;
    logic [16:0]            score_sum;
    logic [15:0]            score_inc;
    logic [BOARD_WIDTH-1:0] gap1, gap2, gap3;

    // Wall with GAP_WIDTH clear columns; out-of-range slices fold back into 0..MAX_POS.
    function automatic logic [BOARD_WIDTH-1:0] gap_field(input logic [5:0] s);
        logic [5:0]             p;
        logic [BOARD_WIDTH-1:0] f;
        p = (int'(s) <= MAX_POS) ? s : s - 6'(MAX_POS + 1);
        f = '1;
        for (int i = 0; i < GAP_WIDTH; i++) begin
            f[p + 6'(i)] = 1'b0;
        end
        return f;
    endfunction

    // A wall hits the player when on the same row and the column is solid or off-board.
    function automatic logic wall_hit(input logic [7:0] y, input logic [BOARD_WIDTH-1:0] f,
                                      input logic [7:0] px, input logic [7:0] py);
        return (y == py) && ((px >= 8'(BOARD_WIDTH)) || f[px[5:0]]);
    endfunction

    // Next-state helpers: LFSR feedback, tick strobe, collision, respawn scoring, fresh gaps.
    always_comb begin
        lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        tick      = (tick_cnt == TICK_LAST);
        collide   = wall_hit(wave1_y, wave1_bitfield, player_x, player_y) |
                    wall_hit(wave2_y, wave2_bitfield, player_x, player_y) |
                    wall_hit(wave3_y, wave3_bitfield, player_x, player_y);
        score_sum = {1'b0, score} + {16'd0, wave1_y == 8'd1}
                                  + {16'd0, wave2_y == 8'd1}
                                  + {16'd0, wave3_y == 8'd1};
        score_inc = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        gap1      = gap_field(lfsr[5:0]);
        gap2      = gap_field(lfsr[11:6]);
        gap3      = gap_field(lfsr[15:10]);
    end

    // Game FSM with all outputs registered; the LFSR free-runs in every state.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all updates see the pre-edge values.
        if (!rst_n) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            lfsr           <= 16'hACE1;
            wave1_y        <= Y1_INIT;
            wave2_y        <= Y2_INIT;
            wave3_y        <= Y3_INIT;
            wave1_bitfield <= '1;
            wave2_bitfield <= '1;
            wave3_bitfield <= '1;
            score          <= '0;
            high_score     <= '0;
            game_over      <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state          <= RUN;
                        tick_cnt       <= '0;
                        wave1_y        <= Y1_INIT;
                        wave2_y        <= Y2_INIT;
                        wave3_y        <= Y3_INIT;
                        wave1_bitfield <= gap1;
                        wave2_bitfield <= gap2;
                        wave3_bitfield <= gap3;
                        score          <= '0;
                        game_over      <= 1'b0;
                    end
                end
                RUN: begin
                    if (collide) begin
                        // Walls and score freeze; a coincident tick is dropped.
                        state     <= OVER;
                        game_over <= 1'b1;
                        if (score > high_score) high_score <= score;
                    end else begin
                        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                        if (tick) begin
                            score <= score_inc;
                            if (wave1_y == 8'd1) begin
                                wave1_y        <= Y1_INIT;
                                wave1_bitfield <= gap1;
                            end else begin
                                wave1_y <= wave1_y - 8'd1;
                            end
                            if (wave2_y == 8'd1) begin
                                wave2_y        <= Y1_INIT;
                                wave2_bitfield <= gap2;
                            end else begin
                                wave2_y <= wave2_y - 8'd1;
                            end
                            if (wave3_y == 8'd1) begin
                                wave3_y        <= Y1_INIT;
                                wave3_bitfield <= gap3;
                            end else begin
                                wave3_y <= wave3_y - 8'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_engine.sv
// tb_wave_engine: randomized bench for wave_engine with a scoreboard.
// The driver steps a behavioural game model on each clock edge and queues the
// expected outputs; a monitor pops and compares them on the falling edge.
module tb_wave_engine;

    localparam int TD = 4;
    localparam int W  = 40;

    typedef struct packed {
        logic [7:0]   y1, y2, y3;
        logic [W-1:0] b1, b2, b3;
        logic [15:0]  sc, hs;
        logic         go;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   player_x = 8'd0;
    logic [7:0]   player_y = 8'd0;
    logic [7:0]   wave1_y, wave2_y, wave3_y;
    logic [W-1:0] wave1_bitfield, wave2_bitfield, wave3_bitfield;
    logic [15:0]  score, high_score;
    logic         game_over;

    int total = 0;
    int bad   = 0;
    obs_t exp_q[$];

    // Reference game state
    bit           m_run;
    int           m_ticks;
    int           m_lfsr;
    logic [7:0]   m_y[3];
    logic [W-1:0] m_bf[3];
    int           m_sc, m_hs;
    bit           m_go;

    wave_engine #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .player_x(player_x), .player_y(player_y),
        .wave1_y(wave1_y), .wave2_y(wave2_y), .wave3_y(wave3_y),
        .wave1_bitfield(wave1_bitfield), .wave2_bitfield(wave2_bitfield),
        .wave3_bitfield(wave3_bitfield),
        .score(score), .high_score(high_score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    function automatic int lfsr_step(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) & 16'hFFFF) | fb;
    endfunction

    function automatic int slice_of(input int l, input int k);
        if (k == 0) return l & 63;
        if (k == 1) return (l >> 6) & 63;
        return (l >> 10) & 63;
    endfunction

    function automatic logic [W-1:0] gap_of(input int s);
        int p;
        logic [W-1:0] f;
        p = (s <= 36) ? s : s - 37;
        f = '1;
        for (int i = p; i < p + 4; i++) f[i] = 1'b0;
        return f;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.y1 = m_y[0]; o.y2 = m_y[1]; o.y3 = m_y[2];
        o.b1 = m_bf[0]; o.b2 = m_bf[1]; o.b3 = m_bf[2];
        o.sc = 16'(m_sc); o.hs = 16'(m_hs); o.go = m_go;
        return o;
    endfunction

    task automatic model_reset();
        m_run = 0; m_ticks = 0; m_lfsr = 16'hACE1;
        for (int k = 0; k < 3; k++) begin
            m_y[k]  = 8'(18 - 6 * k);
            m_bf[k] = '1;
        end
        m_sc = 0; m_hs = 0; m_go = 0;
    endtask

    // Advance the reference by one clock edge using the inputs currently driven.
    task automatic model_step();
        int  nl;
        bit  hit;
        if (!rst_n) begin
            model_reset();
        end else begin
            nl = lfsr_step(m_lfsr);
            if (!m_run) begin
                if (start) begin
                    for (int k = 0; k < 3; k++) begin
                        m_y[k]  = 8'(18 - 6 * k);
                        m_bf[k] = gap_of(slice_of(m_lfsr, k));
                    end
                    m_sc = 0; m_go = 0; m_run = 1; m_ticks = 0;
                end
            end else begin
                hit = 0;
                for (int k = 0; k < 3; k++)
                    if (m_y[k] == player_y && (player_x >= 8'(W) || m_bf[k][player_x] == 1'b1))
                        hit = 1;
                if (hit) begin
                    m_run = 0; m_go = 1;
                    if (m_sc > m_hs) m_hs = m_sc;
                end else begin
                    if (m_ticks % TD == TD - 1) begin
                        for (int k = 0; k < 3; k++) begin
                            if (m_y[k] == 8'd1) begin
                                m_y[k]  = 8'd18;
                                m_bf[k] = gap_of(slice_of(m_lfsr, k));
                                if (m_sc < 65535) m_sc++;
                            end else begin
                                m_y[k] = m_y[k] - 8'd1;
                            end
                        end
                    end
                    m_ticks++;
                end
            end
            m_lfsr = nl;
        end
    endtask

    // Column that is clear in whichever wall currently sits on row py (0 if none).
    function automatic logic [7:0] safe_x(input logic [7:0] py);
        for (int k = 0; k < 3; k++)
            if (m_y[k] == py)
                for (int i = 0; i < W; i++)
                    if (m_bf[k][i] == 1'b0) return 8'(i);
        return 8'd0;
    endfunction

    task automatic step(input logic r, input logic s, input logic [7:0] px, input logic [7:0] py);
        @(negedge clk);
        rst_n = r; start = s; player_x = px; player_y = py;
        @(posedge clk);
        model_step();
        exp_q.push_back(model_obs());
    endtask

    task automatic check(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got y=%0d/%0d/%0d bf=%h/%h/%h sc=%0d hs=%0d go=%b want y=%0d/%0d/%0d bf=%h/%h/%h sc=%0d hs=%0d go=%b",
                     name, $time, act.y1, act.y2, act.y3, act.b1, act.b2, act.b3, act.sc, act.hs, act.go,
                     exp.y1, exp.y2, exp.y3, exp.b1, exp.b2, exp.b3, exp.sc, exp.hs, exp.go);
        end
    endtask

    // Monitor: compare every registered output snapshot against the queued expectation.
    initial begin
        obs_t act, exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act.y1 = wave1_y; act.y2 = wave2_y; act.y3 = wave3_y;
                act.b1 = wave1_bitfield; act.b2 = wave2_bitfield; act.b3 = wave3_bitfield;
                act.sc = score; act.hs = high_score; act.go = game_over;
                check("outputs", act, exp);
            end
        end
    end

    // Driver: directed game scenarios followed by randomized play.
    initial begin
        model_reset();
        // Reset for two cycles, then idle with start low.
        repeat (2) step(1'b0, 1'b0, 8'd0, 8'd0);
        repeat (100) step(1'b1, 1'b0, 8'(($urandom % 60)), 8'(($urandom % 20)));
        // Start pulse, then descend with the player safely on row 0.
        step(1'b1, 1'b1, 8'd0, 8'd0);
        repeat (150) step(1'b1, 1'b0, 8'(($urandom % 60)), 8'd0);
        // Dodge through every wall crossing row 17 so the score keeps climbing.
        repeat (300) step(1'b1, 1'b0, safe_x(8'd17), 8'd17);
        // Off-board column on row 17 forces a collision when the next wall arrives.
        repeat (40) step(1'b1, 1'b0, 8'd50, 8'd17);
        // Restart from OVER keeps high_score and clears score.
        step(1'b1, 1'b1, 8'd0, 8'd0);
        repeat (30) step(1'b1, 1'b0, 8'd0, 8'd0);
        // Reset mid-run clears everything including high_score.
        step(1'b0, 1'b0, 8'd0, 8'd0);
        repeat (5) step(1'b1, 1'b0, 8'd0, 8'd0);
        // Randomized play: mix of dodging, random positions, start pulses, rare resets.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] py;
            logic [7:0] px;
            py = 8'($urandom % 20);
            px = ($urandom % 2 == 0) ? safe_x(py) : 8'($urandom % 48);
            step(($urandom % 300) != 0, ($urandom % 6) == 0, px, py);
        end
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, wanted 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_engine.md
Name: wave_engine

Overview:
- Game-logic stage that sits directly upstream of packet assembly in the dodge game.
- Owns the three falling walls: their row positions and their 40-bit occupancy bitfields.
- Each wall carries a random gap. The block detects player/wall collisions and keeps the current and high score.
- Outputs feed the packet assembler; player_x/player_y come from the button-driven position registers.

Parameters:
- BOARD_HEIGHT, 20, board rows; a wall spawns at row BOARD_HEIGHT-2.
- BOARD_WIDTH, 40, board columns; equals the bitfield width. Fixed at 40 for this revision.
- WAVE_SPACING, 6, row offset between consecutive walls at start.
- GAP_WIDTH, 4, number of clear columns in each wall.
- TICK_DIV, 50000000, clk cycles per wall-move tick; must be >= 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level; sampled in IDLE/OVER to begin a game (debounced center button).
- player_x  in  8  player column.
- player_y  in  8  player row.
- wave1_y, wave2_y, wave3_y  out  8 each  wall rows.
- wave1_bitfield, wave2_bitfield, wave3_bitfield  out  40 each  bit i=1 means column i is solid.
- score  out  16  current score.
- high_score  out  16  best score since reset.
- game_over  out  1  high while in OVER.

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n).
- Reset values:
  - state=IDLE; tick counter=0; LFSR=16'hACE1.
  - waveK_y = BOARD_HEIGHT-2-(K-1)*WAVE_SPACING, i.e. 18/12/6 with defaults.
  - All bitfields = 40'hFFFFFFFFFF.
  - score=0, high_score=0, game_over=0.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1).
  - Shifts left once every clk in every state; the new bit 0 is the XOR of the tapped bits.
- Gap position from a 6-bit slice s:
  - p = s if s <= BOARD_WIDTH-GAP_WIDTH, else s-(BOARD_WIDTH-GAP_WIDTH+1).
  - Range 0..36 with defaults.
  - Bitfield = all ones with bits p..p+GAP_WIDTH-1 cleared.
- Tick:
  - Counter runs only in RUN and counts 0..TICK_DIV-1.
  - tick is asserted on the cycle the counter equals TICK_DIV-1; the counter then wraps to 0.
  - The counter is cleared on the start transition.
- States:
  - IDLE: outputs hold. If start=1, go to RUN next cycle and load:
    - y values as at reset;
    - wave1/2/3 bitfields from gap slices lfsr[5:0], lfsr[11:6], lfsr[15:10] (current LFSR value);
    - score=0.
  - RUN, on tick, for each wall:
    - if y==1: y=BOARD_HEIGHT-2, bitfield regenerated from lfsr[5:0], lfsr[11:6], lfsr[15:10] for walls 1, 2, 3 respectively; score+1, saturating at 16'hFFFF;
    - else y=y-1.
    - Two walls respawning on the same tick each add 1.
  - RUN, collision:
    - Evaluated every cycle on the registered outputs.
    - Collision if any K has waveK_y==player_y and (player_x>=BOARD_WIDTH or waveK_bitfield[player_x]==1).
    - Collision moves the block to OVER next cycle. If a tick coincides with a collision, the wall update and score increment for that tick are suppressed.
    - start is ignored in RUN.
  - OVER:
    - game_over=1; walls and score frozen.
    - high_score updated to score on entry if score>high_score; only the same cycle the state becomes OVER.
    - start=1 performs the same load as IDLE→RUN, and game_over goes 0 on that transition.
- rst_n low in any state restores all reset values next edge, including high_score.
- Latency:
  - Wall and score update visible 1 cycle after the tick cycle.
  - game_over visible 1 cycle after the collision cycle.

Test Plan:
- Reset then hold: rst_n=0 two cycles, then release with start=0 for 100 cycles → y=18/12/6, bitfields 40'hFFFFFFFFFF, score=0, game_over=0 throughout.
- Start load (TICK_DIV=4): pulse start one cycle → state RUN, score=0, and each bitfield has exactly 4 clear bits at the position computed from the reference LFSR model; y values still 18/12/6.
- Descent and respawn (TICK_DIV=4, player kept in a gap column or at player_y=0):
  - y values decrement every 4 cycles.
  - wave3 goes from 1 to 18 at its 6th tick with a new bitfield, and score becomes 1 on that cycle+1.
- Collision (player_x=50, player_y=17 during RUN): on wave1 reaching row 17, game_over=1 one cycle later; wall values frozen; high_score equals score if larger.
- Gap pass (player_x set to a cleared bit of wave1 at player_y=17): no game_over while wave1_y=17; score continues.
- Restart and reset priority:
  - start in OVER → game_over=0, score=0, high_score retained.
  - rst_n=0 mid-RUN → all outputs at reset values, including high_score=0.
